// File: rtl/ser_pkg.sv
// Shared types and sizing helpers for the serial byte collector slice.
package ser_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_e;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned CNT_W_DEF  = $clog2(DATA_W_DEF + 1);

    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/ser_out_hold.sv
// Single-entry valid/ready holding register; flags a dropped word when a load
// arrives while the held word is neither empty nor being consumed.
module ser_out_hold
    import ser_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              overrun
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (load_valid) begin
            // Load is allowed when empty or when the held word leaves on this same edge.
            if (!valid_q || out_ready) begin
                data_d  = load_data;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign overrun   = overrun_q;

endmodule

// File: rtl/ser_byte_collector.sv
// Serial-to-parallel collector: shifts qualified bits into a DATA_W-bit word
// and hands each completed word to a one-entry valid/ready holding register.
module ser_byte_collector
    import ser_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ser_in,
    input  logic                         ser_valid,
    input  logic                         frame_start,
    output logic [DATA_W-1:0]            byte_out,
    output logic                         byte_valid,
    input  logic                         byte_ready,
    output logic [$clog2(DATA_W+1)-1:0]  bit_cnt,
    output logic                         overrun
);

    localparam int unsigned      CNT_W    = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] base_shift;
    logic [CNT_W-1:0]  base_cnt;
    logic              restart;
    logic              word_done;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        word_done  = 1'b0;
        restart    = frame_start || (state_q == IDLE);
        base_shift = restart ? '0 : shift_q;
        base_cnt   = restart ? '0 : cnt_q;
        if (ser_valid) begin
            if (MSB_FIRST) begin
                shift_d = {base_shift[DATA_W-2:0], ser_in};
            end else begin
                shift_d = {ser_in, base_shift[DATA_W-1:1]};
            end
            // shift_d already holds the final bit, so it is the completion word.
            if (base_cnt == LAST_CNT) begin
                cnt_d     = '0;
                state_d   = IDLE;
                word_done = 1'b1;
            end else begin
                cnt_d   = base_cnt + CNT_W'(1);
                state_d = COLLECT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bit_cnt = cnt_q;

    ser_out_hold #(
        .DATA_W (DATA_W)
    ) u_hold (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (word_done),
        .load_data  (shift_d),
        .out_ready  (byte_ready),
        .out_data   (byte_out),
        .out_valid  (byte_valid),
        .overrun    (overrun)
    );

endmodule

// File: tb/tb_ser_byte_collector.sv
// Bench for ser_byte_collector: LSB-first and MSB-first instances share stimulus
// and are checked against a bit-queue reference model plus directed sequences.
module tb_ser_byte_collector;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ser_in = 1'b0;
    logic       ser_valid = 1'b0;
    logic       frame_start = 1'b0;
    logic       byte_ready = 1'b0;

    logic [7:0] out0, out1;
    logic       v0, v1, ov0, ov1;
    logic [3:0] cnt0, cnt1;

    always #5 clk = ~clk;

    ser_byte_collector #(
        .DATA_W    (W),
        .MSB_FIRST (1'b0)
    ) u_lsb (
        .clk         (clk),
        .rst_n       (rst_n),
        .ser_in      (ser_in),
        .ser_valid   (ser_valid),
        .frame_start (frame_start),
        .byte_out    (out0),
        .byte_valid  (v0),
        .byte_ready  (byte_ready),
        .bit_cnt     (cnt0),
        .overrun     (ov0)
    );

    ser_byte_collector #(
        .DATA_W    (W),
        .MSB_FIRST (1'b1)
    ) u_msb (
        .clk         (clk),
        .rst_n       (rst_n),
        .ser_in      (ser_in),
        .ser_valid   (ser_valid),
        .frame_start (frame_start),
        .byte_out    (out1),
        .byte_valid  (v1),
        .byte_ready  (byte_ready),
        .bit_cnt     (cnt1),
        .overrun     (ov1)
    );

    // Reference model: received bits kept as a list; word built by position.
    logic       q_bits[$];
    logic [7:0] m_word0, m_word1;
    logic       m_valid, m_ov;

    int total = 0;
    int bad = 0;
    int ov_seen = 0;

    typedef struct {
        logic       sv;
        logic       b;
        logic       fs;
        logic       rdy;
        logic       ev;
        logic [3:0] ecnt;
        logic [7:0] eout0;
        logic [7:0] eout1;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_bits.delete();
        m_word0 = '0;
        m_word1 = '0;
        m_valid = 1'b0;
        m_ov    = 1'b0;
    endtask

    task automatic model_edge(input logic sv, input logic b, input logic fs, input logic rdy);
        logic       done;
        logic       new_ov;
        logic [7:0] w0, w1;
        done   = 1'b0;
        new_ov = 1'b0;
        w0     = '0;
        w1     = '0;
        if (sv) begin
            if (fs) q_bits.delete();
            q_bits.push_back(b);
            if (q_bits.size() == W) begin
                done = 1'b1;
                for (int i = 0; i < W; i++) begin
                    w0[i]       = q_bits[i];
                    w1[W-1-i]   = q_bits[i];
                end
                q_bits.delete();
            end
        end
        if (done) begin
            if (!m_valid || rdy) begin
                m_valid = 1'b1;
                m_word0 = w0;
                m_word1 = w1;
            end else begin
                new_ov = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        m_ov = new_ov;
    endtask

    task automatic check_model();
        check("valid_lsb", 32'(v0), 32'(m_valid));
        check("valid_msb", 32'(v1), 32'(m_valid));
        check("cnt_lsb", 32'(cnt0), 32'(q_bits.size()));
        check("cnt_msb", 32'(cnt1), 32'(q_bits.size()));
        check("ovr_lsb", 32'(ov0), 32'(m_ov));
        check("ovr_msb", 32'(ov1), 32'(m_ov));
        if (m_valid) begin
            check("word_lsb", 32'(out0), 32'(m_word0));
            check("word_msb", 32'(out1), 32'(m_word1));
        end
    endtask

    task automatic cycle(input logic sv, input logic b, input logic fs, input logic rdy);
        ser_valid   = sv;
        ser_in      = b;
        frame_start = fs;
        byte_ready  = rdy;
        @(posedge clk);
        model_edge(sv, b, fs, rdy);
        #1;
        check_model();
        if (ov0) ov_seen++;
    endtask

    task automatic send_bits(input logic [7:0] w, input int gap, input logic rdy,
                             input logic rdy_last, input logic fs_first);
        for (int i = 0; i < W; i++) begin
            cycle(1'b1, w[i], fs_first && (i == 0), (i == W - 1) ? rdy_last : rdy);
            if (i < W - 1) repeat (gap) cycle(1'b0, 1'b0, 1'b0, rdy);
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_out0"}, 32'(out0), 32'h0);
        check({tag, "_out1"}, 32'(out1), 32'h0);
        check({tag, "_v0"}, 32'(v0), 32'h0);
        check({tag, "_v1"}, 32'(v1), 32'h0);
        check({tag, "_cnt0"}, 32'(cnt0), 32'h0);
        check({tag, "_cnt1"}, 32'(cnt1), 32'h0);
        check({tag, "_ov0"}, 32'(ov0), 32'h0);
        check({tag, "_ov1"}, 32'(ov1), 32'h0);
    endtask

    initial begin
        logic [7:0] d2;
        logic [7:0] bits55;
        d2     = 8'hD2;
        bits55 = 8'h55;
        model_reset();

        // Reset state, held asynchronously before any clock edge.
        #2;
        check_cleared("reset");
        #10;
        rst_n = 1'b1;

        // LSB-first D2 with ready high; MSB-first twin sees 4B.
        for (int i = 0; i < W; i++) begin
            tbl[i].sv    = 1'b1;
            tbl[i].b     = d2[i];
            tbl[i].fs    = 1'b0;
            tbl[i].rdy   = 1'b1;
            tbl[i].ev    = (i == W - 1);
            tbl[i].ecnt  = (i == W - 1) ? 4'd0 : 4'(i + 1);
            tbl[i].eout0 = 8'hD2;
            tbl[i].eout1 = 8'h4B;
        end
        tbl[8] = '{sv: 1'b0, b: 1'b0, fs: 1'b0, rdy: 1'b1, ev: 1'b0, ecnt: 4'd0,
                   eout0: 8'hD2, eout1: 8'h4B};
        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].sv, tbl[i].b, tbl[i].fs, tbl[i].rdy);
            check("tbl_valid", 32'(v0), 32'(tbl[i].ev));
            check("tbl_cnt", 32'(cnt0), 32'(tbl[i].ecnt));
            if (tbl[i].ev) begin
                check("tbl_out_lsb", 32'(out0), 32'(tbl[i].eout0));
                check("tbl_out_msb", 32'(out1), 32'(tbl[i].eout1));
            end
        end

        // MSB-first 1,0,1,0,... with 3-cycle gaps -> AA on the MSB-first instance.
        for (int i = 0; i < W; i++) begin
            cycle(1'b1, bits55[i], 1'b0, 1'b1);
            check("gap_cnt", 32'(cnt1), 32'((i + 1) % W));
            if (i < W - 1) begin
                repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1);
                check("gap_cnt_hold", 32'(cnt1), 32'(i + 1));
            end
        end
        check("gap_word_msb", 32'(out1), 32'hAA);
        check("gap_valid", 32'(v1), 32'h1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Backpressure: F0 held, 0F dropped with one overrun pulse.
        ov_seen = 0;
        send_bits(8'hF0, 0, 1'b0, 1'b0, 1'b0);
        send_bits(8'h0F, 0, 1'b0, 1'b0, 1'b0);
        check("bp_ovr_pulses", 32'(ov_seen), 32'h1);
        check("bp_held", 32'(out0), 32'hF0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("bp_ovr_clear", 32'(ov0), 32'h0);
        check("bp_still_held", 32'(out0), 32'hF0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("bp_drained", 32'(v0), 32'h0);

        // Simultaneous accept of 11 and load of 22.
        send_bits(8'h11, 0, 1'b0, 1'b0, 1'b0);
        check("sim_first", 32'(out0), 32'h11);
        send_bits(8'h22, 0, 1'b0, 1'b1, 1'b0);
        check("sim_out", 32'(out0), 32'h22);
        check("sim_valid", 32'(v0), 32'h1);
        check("sim_ovr", 32'(ov0), 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // frame_start resync after a 5-bit partial word.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        check("fs_partial", 32'(cnt0), 32'h5);
        begin
            logic [7:0] w3c;
            w3c = 8'h3C;
            for (int i = 0; i < W; i++) begin
                cycle(1'b1, w3c[i], i == 0, 1'b1);
                if (i == 0) check("fs_cnt_one", 32'(cnt0), 32'h1);
                if (i < W - 1) check("fs_no_word", 32'(v0), 32'h0);
            end
        end
        check("fs_word", 32'(out0), 32'h3C);
        check("fs_valid", 32'(v0), 32'h1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Async reset while a word is held and another is partial.
        send_bits(8'h99, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("pre_rst_valid", 32'(v0), 32'h1);
        check("pre_rst_cnt", 32'(cnt0), 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        check_cleared("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        check_cleared("rst_held");
        #2;
        rst_n = 1'b1;
        send_bits(8'h5A, 0, 1'b1, 1'b1, 1'b0);
        check("post_rst_word", 32'(out0), 32'h5A);
        check("post_rst_valid", 32'(v0), 32'h1);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
